spi_burst_memory: RTL and testbench

Parametrised SPI-slave register memory, the successor to the lab's fixed 8-bit SPI memory. It adds configurable address and data widths, a configurable synchroniser depth, SPI mode 0 or 3, and burst transfers that auto-increment the address while chip select stays low. It sits behind the FPGA SPI pins and conditions `sclk_pin`, `cs_pin` and `mosi_pin` into the `clk` domain. An internal FSM sequences the header, the data words and the memory accesses.

---
 rtl/spi_burst_memory.sv | 200 ++++++++++++++++++++
 tb/tb_spi_burst_memory.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_burst_memory.sv
// spi_burst_memory: SPI-slave register memory with parametrised address and
// data widths, SPI mode 0/3, and burst transfers that auto-increment the
// address while chip select stays low. Pins are synchronised into clk.
module spi_burst_memory #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 7,
    parameter int SYNC_STAGES = 2,
    parameter int CPOL        = 0
) (
    input  logic clk,
    input  logic resetN,
    input  logic sclk_pin,
    input  logic cs_pin,
    input  logic mosi_pin,
    output logic miso_pin,
    output logic misoEnable,
    output logic writePulse
);

    localparam int MAX_BITS = (ADDR_WIDTH + 1 > DATA_WIDTH) ? ADDR_WIDTH + 1 : DATA_WIDTH;
    localparam int CNT_W    = $clog2(MAX_BITS);

    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(ADDR_WIDTH);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic             SCLK_IDLE = (CPOL != 0);

    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] HEADER      = 3'd1;
    localparam logic [2:0] READ_LOAD   = 3'd2;
    localparam logic [2:0] READ_SHIFT  = 3'd3;
    localparam logic [2:0] WRITE_SHIFT = 3'd4;
    localparam logic [2:0] WRITE_STORE = 3'd5;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_armed_q, cs_armed_d;
    logic [2:0]             state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic                   miso_q, miso_d;
    logic                   miso_en_q, miso_en_d;
    logic                   write_pulse_q, write_pulse_d;

    logic [DATA_WIDTH-1:0]  mem [2**ADDR_WIDTH];

    logic sclk_s, cs_s, mosi_s;
    logic pos_pulse, neg_pulse;
    logic store_pending;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign pos_pulse = sclk_s & ~sclk_prev_q;
    assign neg_pulse = ~sclk_s & sclk_prev_q;

    // A write whose last bit lands together with the CS rise still commits.
    assign store_pending = (state_q == WRITE_STORE) ||
                           ((state_q == WRITE_SHIFT) && pos_pulse && (bit_cnt_q == DATA_LAST));

    assign miso_pin   = miso_q;
    assign misoEnable = miso_en_q;
    assign writePulse = write_pulse_q;

    // Shift each pin one stage deeper into the clk domain.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_pin};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_pin};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_pin};
        sclk_prev_d = sclk_s;
    end

    // Transaction sequencer: header decode, read/write data phases, CS abort.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        state_d       = state_q;
        addr_d        = addr_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        miso_d        = miso_q;
        miso_en_d     = miso_en_q;
        write_pulse_d = 1'b0;
        // Only a genuinely observed idle-high CS arms decoding, so a CS held low
        // across reset release has to be cycled first.
        cs_armed_d    = cs_armed_q | cs_s;

        case (state_q)
            IDLE: begin
                miso_d    = 1'b0;
                miso_en_d = 1'b0;
                bit_cnt_d = '0;
                if (!cs_s && cs_armed_q) state_d = HEADER;
            end
            HEADER: begin
                if (pos_pulse) begin
                    if (bit_cnt_q == HDR_LAST) begin
                        bit_cnt_d = '0;
                        if (mosi_s) begin
                            state_d   = READ_LOAD;
                            miso_en_d = 1'b1;
                        end else begin
                            state_d = WRITE_SHIFT;
                        end
                    end else begin
                        addr_d    = {addr_q[ADDR_WIDTH-2:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            READ_LOAD: begin
                shift_d   = mem[addr_q];
                bit_cnt_d = '0;
                miso_en_d = 1'b1;
                state_d   = READ_SHIFT;
            end
            READ_SHIFT: begin
                if (neg_pulse) begin
                    miso_d  = shift_q[DATA_WIDTH-1];
                    shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
                end
                if (pos_pulse) begin
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        addr_d    = addr_q + ADDR_WIDTH'(1);
                        state_d   = READ_LOAD;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            WRITE_SHIFT: begin
                if (pos_pulse) begin
                    shift_d = {shift_q[DATA_WIDTH-2:0], mosi_s};
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d     = '0;
                        write_pulse_d = 1'b1;
                        state_d       = WRITE_STORE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            WRITE_STORE: begin
                addr_d  = addr_q + ADDR_WIDTH'(1);
                state_d = cs_s ? IDLE : WRITE_SHIFT;
            end
            default: state_d = IDLE;
        endcase

        // CS high abandons whatever is in flight, except a committed store.
        if (cs_s && !store_pending) begin
            state_d   = IDLE;
            miso_d    = 1'b0;
            miso_en_d = 1'b0;
            bit_cnt_d = '0;
        end
    end

    // State and pin-synchroniser registers with asynchronous reset.
    always_ff @(posedge clk or negedge resetN) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!resetN) begin
            sclk_sync_q   <= {SYNC_STAGES{SCLK_IDLE}};
            // CS chain resets to "selected" so a reset value can never arm decoding.
            cs_sync_q     <= '0;
            mosi_sync_q   <= '0;
            sclk_prev_q   <= SCLK_IDLE;
            cs_armed_q    <= 1'b0;
            state_q       <= IDLE;
            addr_q        <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            miso_q        <= 1'b0;
            miso_en_q     <= 1'b0;
            write_pulse_q <= 1'b0;
        end else begin
            sclk_sync_q   <= sclk_sync_d;
            cs_sync_q     <= cs_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            sclk_prev_q   <= sclk_prev_d;
            cs_armed_q    <= cs_armed_d;
            state_q       <= state_d;
            addr_q        <= addr_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            miso_q        <= miso_d;
            miso_en_q     <= miso_en_d;
            write_pulse_q <= write_pulse_d;
        end
    end

    // Memory write port, committed in the WRITE_STORE cycle.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset so it maps onto RAM; contents survive resetN.
        if (state_q == WRITE_STORE) mem[addr_q] <= shift_q;
    end

endmodule

// File: tb/tb_spi_burst_memory.sv
// tb_spi_burst_memory: directed SPI master stimulus for a mode-0 default
// instance and a mode-3 16/4 instance; monitors score writePulse events and
// MISO words against queues filled by the stimulus.
`timescale 1ns/1ps
module tb_spi_burst_memory;

    localparam int HALF = 8;   // clk cycles per SCLK phase

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetN;
    logic sclk0, cs0, mosi0, miso0, men0, wp0;
    logic sclk1, cs1, mosi1, miso1, men1, wp1;

    int n_checks = 0;
    int n_errors = 0;
    int wr_seen0 = 0;
    int wr_seen1 = 0;

    int          wr_q0[$];
    int          wr_q1[$];
    logic [15:0] rd_q0[$];
    logic [15:0] rd_q1[$];

    spi_burst_memory dut0 (
        .clk        (clk),
        .resetN     (resetN),
        .sclk_pin   (sclk0),
        .cs_pin     (cs0),
        .mosi_pin   (mosi0),
        .miso_pin   (miso0),
        .misoEnable (men0),
        .writePulse (wp0)
    );

    spi_burst_memory #(
        .DATA_WIDTH  (16),
        .ADDR_WIDTH  (4),
        .SYNC_STAGES (2),
        .CPOL        (1)
    ) dut1 (
        .clk        (clk),
        .resetN     (resetN),
        .sclk_pin   (sclk1),
        .cs_pin     (cs1),
        .mosi_pin   (mosi1),
        .miso_pin   (miso1),
        .misoEnable (men1),
        .writePulse (wp1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Mode 0: data set while SCLK low, sampled on the rise, SCLK returns low.
    // Mode 3: SCLK falls (data change), then rises (sample), idles high.
    task automatic spi_bit(input int dev, input logic b);
        if (dev == 0) begin
            mosi0 = b;
            tick(HALF);
            sclk0 = 1'b1;
            tick(HALF);
            sclk0 = 1'b0;
        end else begin
            sclk1 = 1'b0;
            mosi1 = b;
            tick(HALF);
            sclk1 = 1'b1;
            tick(HALF);
        end
    endtask

    task automatic spi_send(input int dev, input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) spi_bit(dev, v[i]);
    endtask

    task automatic cs_on(input int dev);
        if (dev == 0) cs0 = 1'b0;
        else          cs1 = 1'b0;
        tick(HALF);
    endtask

    task automatic cs_off(input int dev);
        tick(HALF);
        if (dev == 0) cs0 = 1'b1;
        else          cs1 = 1'b1;
        tick(2 * HALF);
    endtask

    task automatic header(input int dev, input logic [6:0] addr, input logic rw);
        if (dev == 0) spi_send(0, {24'h0, addr, rw}, 8);
        else          spi_send(1, {27'h0, addr[3:0], rw}, 5);
    endtask

    task automatic wr_word(input int dev, input logic [15:0] d);
        if (dev == 0) begin
            wr_q0.push_back(1);
            spi_send(0, {16'h0, d}, 8);
        end else begin
            wr_q1.push_back(1);
            spi_send(1, {16'h0, d}, 16);
        end
    endtask

    task automatic rd_word(input int dev, input logic [15:0] exp);
        if (dev == 0) begin
            rd_q0.push_back(exp);
            spi_send(0, 32'h0, 8);
        end else begin
            rd_q1.push_back(exp);
            spi_send(1, 32'h0, 16);
        end
    endtask

    task automatic drained(input string tag);
        check({tag, "_wr_pending"}, wr_q0.size() + wr_q1.size(), 0);
        check({tag, "_rd_pending"}, rd_q0.size() + rd_q1.size(), 0);
    endtask

    // Write monitors: each writePulse must match an expected write.
    always @(negedge clk) begin
        if (wp0 === 1'b1) begin
            wr_seen0++;
            n_checks++;
            if (wr_q0.size() == 0) begin
                n_errors++;
                $display("FAIL wr0_unexpected: got writePulse expected none");
            end else begin
                void'(wr_q0.pop_front());
            end
        end
        if (wp1 === 1'b1) begin
            wr_seen1++;
            n_checks++;
            if (wr_q1.size() == 0) begin
                n_errors++;
                $display("FAIL wr1_unexpected: got writePulse expected none");
            end else begin
                void'(wr_q1.pop_front());
            end
        end
    end

    // Read monitor, mode-0 instance: assemble MISO on master sampling edges.
    initial begin : mon_rd0
        int          cnt;
        logic [7:0]  w;
        cnt = 0;
        w   = '0;
        forever begin
            @(posedge sclk0);
            if (men0 !== 1'b1) begin
                cnt = 0;
            end else begin
                w = {w[6:0], miso0};
                cnt++;
                if (cnt == 8) begin
                    cnt = 0;
                    if (rd_q0.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL rd0_unexpected: got 0x%0h expected no word", w);
                    end else begin
                        check("rd0_word", {24'h0, w}, {16'h0, rd_q0.pop_front()});
                    end
                end
            end
        end
    end

    // Read monitor, mode-3 instance.
    initial begin : mon_rd1
        int          cnt;
        logic [15:0] w;
        cnt = 0;
        w   = '0;
        forever begin
            @(posedge sclk1);
            if (men1 !== 1'b1) begin
                cnt = 0;
            end else begin
                w = {w[14:0], miso1};
                cnt++;
                if (cnt == 16) begin
                    cnt = 0;
                    if (rd_q1.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL rd1_unexpected: got 0x%0h expected no word", w);
                    end else begin
                        check("rd1_word", {16'h0, w}, {16'h0, rd_q1.pop_front()});
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "time limit");
    end

    initial begin : stimulus
        resetN = 1'b0;
        sclk0  = 1'b0;
        cs0    = 1'b0;
        mosi0  = 1'b0;
        sclk1  = 1'b1;
        cs1    = 1'b1;
        mosi1  = 1'b0;

        // Reset held with CS low and SCLK toggling.
        for (int i = 0; i < 4; i++) begin
            spi_bit(0, i[0]);
            check("rst_miso", {31'h0, miso0}, 0);
            check("rst_misoEnable", {31'h0, men0}, 0);
            check("rst_writePulse", {31'h0, wp0}, 0);
        end
        resetN = 1'b1;
        tick(4);
        // CS never cycled: a full write frame must be ignored.
        header(0, 7'h12, 1'b0);
        spi_send(0, 32'hFF, 8);
        cs_off(0);
        check("no_write_after_rst", wr_seen0, 0);
        drained("reset");

        // Single word write then read.
        cs_on(0); header(0, 7'h12, 1'b0); wr_word(0, 16'hA5); cs_off(0);
        check("single_wr_count", wr_seen0, 1);
        cs_on(0); header(0, 7'h12, 1'b1); rd_word(0, 16'hA5); cs_off(0);
        drained("single");

        // Burst write across the top address, burst read back, wrap check.
        cs_on(0); header(0, 7'h7E, 1'b0);
        wr_word(0, 16'h11); wr_word(0, 16'h22); wr_word(0, 16'h33);
        cs_off(0);
        check("burst_wr_count", wr_seen0, 4);
        cs_on(0); header(0, 7'h7E, 1'b1);
        rd_word(0, 16'h11); rd_word(0, 16'h22); rd_word(0, 16'h33);
        cs_off(0);
        cs_on(0); header(0, 7'h00, 1'b1); rd_word(0, 16'h33); cs_off(0);
        drained("burst");

        // CS abort after 5 data bits leaves the old value in place.
        cs_on(0); header(0, 7'h05, 1'b0); wr_word(0, 16'h5A); cs_off(0);
        cs_on(0); header(0, 7'h05, 1'b0); spi_send(0, 32'h1F, 5); cs_off(0);
        check("abort_wr_count", wr_seen0, 5);
        cs_on(0); header(0, 7'h05, 1'b1); rd_word(0, 16'h5A); cs_off(0);
        drained("abort");

        // Reset during the third data bit of a read of 0xA5.
        cs_on(0); header(0, 7'h12, 1'b1);
        spi_bit(0, 1'b0);
        spi_bit(0, 1'b0);
        mosi0 = 1'b0;
        tick(HALF - 2);
        check("midrd_misoEnable_before", {31'h0, men0}, 1);
        check("midrd_miso_before", {31'h0, miso0}, 1);
        resetN = 1'b0;
        #1;
        check("midrd_misoEnable_rst", {31'h0, men0}, 0);
        check("midrd_miso_rst", {31'h0, miso0}, 0);
        tick(4);
        resetN = 1'b1;
        tick(4);
        cs_off(0);
        cs_on(0); header(0, 7'h7F, 1'b1); rd_word(0, 16'h22); cs_off(0);
        check("midrd_wr_count", wr_seen0, 5);
        drained("midrd");

        // Mode 3, 16-bit data, 4-bit address, burst with wrap.
        cs_on(1); header(1, 7'h0F, 1'b0);
        wr_word(1, 16'hBEEF); wr_word(1, 16'h1234);
        cs_off(1);
        check("mode3_wr_count", wr_seen1, 2);
        cs_on(1); header(1, 7'h0F, 1'b1);
        rd_word(1, 16'hBEEF); rd_word(1, 16'h1234);
        cs_off(1);
        drained("mode3");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
